// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer with programmable wait states and a word-addressed register bank.
// Register 0 is a read-only ID; the remaining registers are read/write and exported on regs_o.
module apb_slave_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWRDATA,
    input  logic [3:0]                     wait_cfg_i,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic                           wr_strobe_o,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0]   bank [NUM_REGS];
    logic                    wr_strobe_q;
    logic [IDX_W-1:0]        wr_idx_q;
    logic [IDX_W-1:0]        idx;
    logic                    err, we;

    assign idx = PADDR[2 +: IDX_W];
    // Any address bit above the bank window set means out of range.
    assign err = (PADDR[1:0] != 2'b00) || ((PADDR >> (IDX_W + 2)) != '0) || (PWRITE && idx == '0);
    assign PREADY = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign PSLVERR = PREADY && err;
    assign PRDATA = (PREADY && !PWRITE && !err) ? bank[idx] : '0;
    assign we = PREADY && PWRITE && !err;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_idx_o = wr_idx_q;

    assign bank[0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_bank
        assign bank[g] = regs_q[g];
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = bank[g];
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (PSEL && !PENABLE) begin
                state_d = ACCESS;
                cnt_d = wait_cfg_i;
            end
        end else if (!PSEL) begin
            state_d = IDLE;
        end else if (!PENABLE) begin
            cnt_d = wait_cfg_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q <= '0;
            wr_strobe_q <= 1'b0;
            wr_idx_q <= '0;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wr_strobe_q <= we;
            if (we) wr_idx_q <= idx;
            for (int i = 1; i < NUM_REGS; i++)
                if (we && idx == IDX_W'(i)) regs_q[i] <= PWRDATA;
        end
    end
endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB completer (slave) with a word-addressed register bank; it is the responder end for the team's APB master.
- Decodes PSEL/PENABLE/PWRITE/PADDR and inserts a programmable number of wait states before asserting PREADY.
- Commits writes and returns read data; flags bad accesses on PSLVERR.
- Exposes register contents and a write-strobe to downstream logic.

Parameters:
DATA_WIDTH, 32, width of PWRDATA/PRDATA and of each register
ADDR_WIDTH, 32, width of PADDR
NUM_REGS, 16, number of registers; power of 2, minimum 2
ID_VALUE, 32'hA5B0_0001, constant value of read-only register 0

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  asynchronous, active-high reset
PSEL  input  1  slave select from master
PENABLE  input  1  access phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_WIDTH  byte address
PWRDATA  input  DATA_WIDTH  write data
wait_cfg_i  input  4  wait states for next transfer, sampled in SETUP
PRDATA  output  DATA_WIDTH  read data
PREADY  output  1  transfer completes this cycle
PSLVERR  output  1  error response, valid only with PREADY
regs_o  output  NUM_REGS*DATA_WIDTH  flattened register bank; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_strobe_o  output  1  one-cycle pulse after a committed write
wr_idx_o  output  log2(NUM_REGS)  index of last committed write

Behaviour:
- Reset (PRESET=1, asynchronous):
  - state=IDLE, wait counter=0, regs 1..NUM_REGS-1 = 0.
  - PREADY=0, PSLVERR=0, PRDATA=0, wr_strobe_o=0, wr_idx_o=0.
- Register 0 always reads ID_VALUE and is never written. regs_o slice 0 = ID_VALUE.
- Decode: idx = PADDR[2 +: log2(NUM_REGS)].
  - err_addr when PADDR[1:0]!=0 or PADDR >= NUM_REGS*4.
  - err_ro when PWRITE=1 and idx==0.
  - err = err_addr | err_ro.
- FSM states: IDLE, ACCESS.
  - IDLE: when PSEL=1 and PENABLE=0 (setup phase), load counter with wait_cfg_i and go to ACCESS. All other inputs keep IDLE.
  - ACCESS, PSEL=1 and PENABLE=1, counter!=0: decrement counter, PREADY=0.
  - ACCESS, PSEL=1 and PENABLE=1, counter==0: PREADY=1 combinationally. At the next edge go to IDLE.
  - ACCESS, PSEL=0 (master abort): go to IDLE. No write, no strobe, PREADY stays 0.
  - ACCESS, PSEL=1 and PENABLE=0 (new setup without completion): treat as new setup; reload counter, stay ACCESS.
- Latency: PREADY rises wait_cfg+1 cycles after the setup cycle.
  - wait_cfg=0 gives the minimal 2-cycle APB transfer.
  - wait_cfg=15 gives 17 cycles.
- PREADY, PSLVERR and PRDATA are combinational from state, counter and current bus inputs.
- PSLVERR = PREADY & err. It is 0 whenever PREADY=0.
- PRDATA:
  - read (PWRITE=0), PREADY=1, err=0: addressed register (ID_VALUE for idx 0).
  - all other cases: 0.
- Write commit: on the rising edge where PREADY=1, PWRITE=1 and err=0:
  - reg[idx] <= PWRDATA.
  - next cycle wr_strobe_o=1 and wr_idx_o=idx.
  - wr_strobe_o is 0 otherwise. wr_idx_o holds its last value.
- An erroring write completes normally (PREADY=1) but changes nothing and raises no strobe.
- PADDR, PWRITE and PWRDATA are used as presented on the completion cycle; the master holds them stable through ACCESS.
- Back-to-back transfers: a setup on the cycle right after completion is accepted from IDLE. There are no idle cycles inside the slave.
- Reset asserted mid-ACCESS aborts the transfer: no write, outputs take reset values immediately.

Test Plan:
- Reset then idle bus -> PREADY=0, PSLVERR=0, PRDATA=0; regs_o slice 0 = 32'hA5B00001, all other slices 0.
- wait_cfg=0, write 32'hDEADBEEF to PADDR 0x08, then read 0x08 -> each transfer is 2 cycles with PREADY high on the 2nd. reg2=DEADBEEF. wr_strobe_o pulses once with wr_idx_o=2. Read returns DEADBEEF, PSLVERR=0.
- wait_cfg=3, read 0x00 -> PREADY low for 3 ACCESS cycles, high on the 4th with PRDATA=32'hA5B00001.
- Write to 0x00, write to 0x40 (NUM_REGS=16), read 0x06 -> each completes with PREADY=1 and PSLVERR=1. No strobe, regs unchanged, PRDATA=0.
- wait_cfg=5 write to 0x0C, PSEL dropped after 2 ACCESS cycles -> FSM returns to IDLE, reg3 unchanged, no strobe. A following wait_cfg=0 read of 0x0C completes in 2 cycles returning 0.
- PRESET pulsed during ACCESS of a wait_cfg=4 write 32'h12345678 to 0x04 -> PREADY=0 at once, reg1=0 after reset, no strobe.
